// File: rtl/sevenseg_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment display: hex glyph table,
// all-off patterns and the per-slot phase encoding.
package sevenseg_scan_driver_pkg;

    localparam logic [3:0] ANODE_OFF = 4'hF;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry [n] is the glyph for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        ST_GUARD  = 1'b0,
        ST_ACTIVE = 1'b1
    } slot_state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_hex7seg_decode.sv
// Combinational nibble to active-low segment decoder with a blank override.
module hex7seg_decode
    import sevenseg_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg_n
);

    // Blanked digits show nothing; otherwise look up the glyph.
    always_comb begin
        seg_n = SEG_OFF;
        if (blank) begin
            seg_n = SEG_OFF;
        end else begin
            seg_n = hex_to_seg(nibble);
        end
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Four-digit common-anode scan driver with tear-free frame latching,
// anti-ghosting guard interval and 16-level brightness PWM.
module sevenseg_scan_driver
    import sevenseg_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic        digits_valid,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  dp,
    input  logic [3:0]  brightness,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_start
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam slot_state_e FIRST_STATE = (GUARD_CYCLES == 0) ? ST_ACTIVE : ST_GUARD;

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       pwm_cnt_q, pwm_cnt_d;
    logic [15:0]      pending_q, pending_d;
    logic [15:0]      shadow_q, shadow_d;
    slot_state_e      state_q, state_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_n_q, dp_n_d;
    logic             frame_start_q, frame_start_d;

    logic             slot_end;
    logic             frame_wrap;
    logic [6:0]       dec_seg;

    hex7seg_decode u_decode (
        .nibble (shadow_q[{idx_q, 2'b00} +: 4]),
        .blank  (blank_mask[idx_q]),
        .seg_n  (dec_seg)
    );

    // Next-state logic; outputs reflect the slot phase of the current cycle.
    always_comb begin
        slot_end   = (slot_cnt_q == LAST_SLOT);
        frame_wrap = slot_end && (idx_q == 2'd3);

        slot_cnt_d = slot_end ? {CNT_W{1'b0}} : slot_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        idx_d      = slot_end ? idx_q + 2'd1 : idx_q;
        pwm_cnt_d  = pwm_cnt_q + 4'd1;
        pending_d  = digits_valid ? digits : pending_q;

        // Shadow only moves at the frame boundary; a same-cycle strobe bypasses pending.
        if (frame_wrap) begin
            shadow_d = digits_valid ? digits : pending_q;
        end else begin
            shadow_d = shadow_q;
        end

        state_d = state_q;
        case (state_q)
            ST_GUARD: begin
                if (slot_cnt_q == GUARD_LAST) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_GUARD;
                end
            end
            ST_ACTIVE: begin
                if (slot_end) begin
                    state_d = FIRST_STATE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: state_d = FIRST_STATE;
        endcase

        if ((state_q == ST_ACTIVE) && (pwm_cnt_q <= brightness)) begin
            an_d = ~(4'b0001 << idx_q);
        end else begin
            an_d = ANODE_OFF;
        end

        if (slot_cnt_q == {CNT_W{1'b0}}) begin
            seg_d  = dec_seg;
            dp_n_d = blank_mask[idx_q] ? 1'b1 : ~dp[idx_q];
        end else begin
            seg_d  = seg_q;
            dp_n_d = dp_n_q;
        end

        frame_start_d = (slot_cnt_q == {CNT_W{1'b0}}) && (idx_q == 2'd0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q    <= {CNT_W{1'b0}};
            idx_q         <= 2'd0;
            pwm_cnt_q     <= 4'd0;
            pending_q     <= 16'h0000;
            shadow_q      <= 16'h0000;
            state_q       <= FIRST_STATE;
            an_q          <= ANODE_OFF;
            seg_q         <= SEG_OFF;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            idx_q         <= idx_d;
            pwm_cnt_q     <= pwm_cnt_d;
            pending_q     <= pending_d;
            shadow_q      <= shadow_d;
            state_q       <= state_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_n_q        <= dp_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp_n        = dp_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Randomized scoreboard bench: a time-based reference model predicts every
// output cycle; a monitor compares the DUT against the queued predictions.
module tb_sevenseg_scan_driver;

    localparam int R = 8;
    localparam int G = 2;
    localparam int FRAME = 4 * R;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic        digits_valid;
    logic [3:0]  blank_mask;
    logic [3:0]  dp;
    logic [3:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_start;

    sevenseg_scan_driver #(.REFRESH_DIV(R), .GUARD_CYCLES(G)) dut (
        .clk          (clk),
        .reset        (reset),
        .digits       (digits),
        .digits_valid (digits_valid),
        .blank_mask   (blank_mask),
        .dp           (dp),
        .brightness   (brightness),
        .an           (an),
        .seg          (seg),
        .dp_n         (dp_n),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;

    logic [6:0]  hex_ref [0:15];
    logic [3:0]  cur_bm, cur_dp, cur_br;

    // Reference model: k counts cycles since reset released.
    int          k;
    logic [15:0] m_pending, m_shadow;
    logic [6:0]  m_seg;
    logic        m_dp_n;

    task automatic drive_cycle(input logic rst, input logic v, input logic [15:0] d);
        exp_t       e;
        int         slot, idx;
        logic [3:0] onehot, nib;
        @(negedge clk);
        reset        = rst;
        digits_valid = v;
        digits       = d;
        blank_mask   = cur_bm;
        dp           = cur_dp;
        brightness   = cur_br;
        if (rst) begin
            e = '{an: 4'hF, seg: 7'h7F, dp_n: 1'b1, fs: 1'b0};
            k = 0;
            m_pending = 16'h0000;
            m_shadow  = 16'h0000;
            m_seg     = 7'h7F;
            m_dp_n    = 1'b1;
        end else begin
            slot = k % R;
            idx  = (k / R) % 4;
            if (slot == 0) begin
                if (cur_bm[idx]) begin
                    m_seg  = 7'h7F;
                    m_dp_n = 1'b1;
                end else begin
                    nib    = m_shadow[idx*4 +: 4];
                    m_seg  = hex_ref[nib];
                    m_dp_n = ~cur_dp[idx];
                end
            end
            onehot = 4'b0001 << idx;
            e.an   = (slot >= G && (k % 16) <= int'(cur_br)) ? ~onehot : 4'hF;
            e.seg  = m_seg;
            e.dp_n = m_dp_n;
            e.fs   = (k % FRAME == 0);
            if (k % FRAME == FRAME - 1) m_shadow = v ? d : m_pending;
            if (v) m_pending = d;
            k++;
        end
        exp_q.push_back(e);
        started = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic idle_until_phase(input int phase);
        for (int i = 0; i < FRAME && (k % FRAME) != phase; i++) idle(1);
    endtask

    // Monitor: one comparison per output cycle against the oldest prediction.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (started) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL queue_empty at t=%0t: no prediction for this cycle", $time);
            end else begin
                e = exp_q.pop_front();
                if ({an, seg, dp_n, frame_start} !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got an=%h seg=%h dp_n=%b fs=%b expected an=%h seg=%h dp_n=%b fs=%b",
                             $time, an, seg, dp_n, frame_start, e.an, e.seg, e.dp_n, e.fs);
                end
            end
        end
    end

    initial begin
        hex_ref[0]  = 7'h40; hex_ref[1]  = 7'h79; hex_ref[2]  = 7'h24; hex_ref[3]  = 7'h30;
        hex_ref[4]  = 7'h19; hex_ref[5]  = 7'h12; hex_ref[6]  = 7'h02; hex_ref[7]  = 7'h78;
        hex_ref[8]  = 7'h00; hex_ref[9]  = 7'h10; hex_ref[10] = 7'h08; hex_ref[11] = 7'h03;
        hex_ref[12] = 7'h46; hex_ref[13] = 7'h21; hex_ref[14] = 7'h06; hex_ref[15] = 7'h0E;
        reset = 1'b1; digits_valid = 1'b0; digits = 16'h0000;
        blank_mask = 4'h0; dp = 4'h0; brightness = 4'hF;
        cur_bm = 4'h0; cur_dp = 4'h0; cur_br = 4'hF;
        k = 0; m_pending = 16'h0000; m_shadow = 16'h0000; m_seg = 7'h7F; m_dp_n = 1'b1;

        repeat (3) drive_cycle(1'b1, 1'b0, 16'h0000);

        // Strobe just after frame_start, then watch the following frame.
        idle(1);
        drive_cycle(1'b0, 1'b1, 16'h12AF);
        idle(2 * FRAME);

        // Two strobes in a frame, then a strobe on the wrap cycle.
        idle(3);
        drive_cycle(1'b0, 1'b1, 16'h1111);
        idle(4);
        drive_cycle(1'b0, 1'b1, 16'h2222);
        idle_until_phase(FRAME - 1);
        idle(FRAME);
        drive_cycle(1'b0, 1'b1, 16'h3333);
        idle(FRAME);

        // Blanking and decimal points.
        cur_bm = 4'b1000; cur_dp = 4'b0001;
        idle(2 * FRAME);
        cur_bm = 4'b0000; cur_dp = 4'b0000;

        // Brightness extremes and midpoint.
        cur_br = 4'd0;  idle(2 * FRAME);
        cur_br = 4'd7;  idle(2 * FRAME);
        cur_br = 4'd15; idle(FRAME);

        // Randomized traffic with live control changes.
        for (int i = 0; i < 40 * FRAME; i++) begin
            if ($urandom_range(0, 15) == 0) cur_br = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) cur_bm = 4'($urandom);
            if ($urandom_range(0, 63) == 0) cur_dp = 4'($urandom);
            drive_cycle(1'b0, ($urandom_range(0, 5) == 0), 16'($urandom));
        end

        // Mid-slot reset at slot_cnt=5, idx=2.
        cur_br = 4'd15; cur_bm = 4'h0; cur_dp = 4'h0;
        drive_cycle(1'b0, 1'b1, 16'hBEEF);
        idle_until_phase(2 * R + 5);
        drive_cycle(1'b1, 1'b0, 16'h0000);
        idle(3 * FRAME);
        drive_cycle(1'b0, 1'b1, 16'hC0DE);
        idle(2 * FRAME);

        @(posedge clk);
        #2;
        started = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
